// File: rtl/alba_pkg.sv
// Shared definitions for the albaCore sequencer: opcodes, FSM states,
// instruction classes and write-source selects.
package alba_pkg;

    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic RF_WSEL_ALU = 1'b0;
    localparam logic RF_WSEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LD,
        CL_ST,
        CL_BZ,
        CL_JMP,
        CL_NOP,
        CL_HALT
    } iclass_e;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/alba_ctrl_if.sv
// Single-port memory bus between the sequencer (master) and memory (slave).
interface alba_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/alba_decode.sv
// Combinational instruction decoder: splits the IR into register/ALU fields
// and classifies the opcode.
module alba_decode
    import alba_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [3:0]  rd_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [2:0]  alu_op_o,
    output logic [7:0]  imm_o,
    output logic [3:0]  shamt_o,
    output iclass_e     iclass_o
);

    assign rd_o     = ir_i[11:8];
    assign ra_o     = ir_i[7:4];
    assign rb_o     = ir_i[3:0];
    assign alu_op_o = ir_i[14:12];
    assign imm_o    = ir_i[7:0];
    assign shamt_o  = ir_i[3:0];

    always_comb begin
        iclass_o = CL_NOP;
        if (!ir_i[15]) begin
            iclass_o = CL_ALU;
        end else begin
            case (ir_i[15:12])
                OP_LD:   iclass_o = CL_LD;
                OP_ST:   iclass_o = CL_ST;
                OP_BZ:   iclass_o = CL_BZ;
                OP_JMP:  iclass_o = CL_JMP;
                OP_HALT: iclass_o = CL_HALT;
                default: iclass_o = CL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/alba_ctrl.sv
// albaCore fetch/decode/execute sequencer: owns PC, IR and the FSM that
// drives the memory bus, register-file strobes and ALU controls.
module alba_ctrl
    import alba_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    alba_ctrl_if.master mem_bus,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic [3:0]  rf_rd,
    input  logic [15:0] rf_a,
    input  logic [15:0] rf_b,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_imm,
    output logic [3:0]  alu_shamt,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  dec_rd, dec_ra, dec_rb;
    logic [7:0]  dec_imm;
    iclass_e     dec_class;

    alba_decode u_decode (
        .ir_i     (ir_q),
        .rd_o     (dec_rd),
        .ra_o     (dec_ra),
        .rb_o     (dec_rb),
        .alu_op_o (alu_op),
        .imm_o    (dec_imm),
        .shamt_o  (alu_shamt),
        .iclass_o (dec_class)
    );

    // BZ tests rd, so it is routed onto read port A.
    assign rf_ra   = (dec_class == CL_BZ) ? dec_rd : dec_ra;
    assign rf_rb   = dec_rb;
    assign rf_rd   = dec_rd;
    assign alu_imm = dec_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_bus.mem_ack) begin
                    ir_d    = mem_bus.mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (dec_class)
                    CL_LD, CL_ST: state_d = ST_MEM;
                    CL_BZ: begin
                        // pc_q already points past the branch here.
                        if (rf_a == 16'h0000) pc_d = pc_q + sext8(dec_imm);
                    end
                    CL_JMP:  pc_d    = rf_a;
                    CL_HALT: state_d = ST_HALT;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_bus.mem_ack) state_d = ST_FETCH;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        mem_bus.mem_req   = 1'b0;
        mem_bus.mem_we    = 1'b0;
        mem_bus.mem_addr  = 16'h0000;
        mem_bus.mem_wdata = 16'h0000;
        rf_we             = 1'b0;
        rf_wsel           = RF_WSEL_ALU;
        halted            = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_bus.mem_req  = 1'b1;
                mem_bus.mem_addr = pc_q;
            end
            ST_EXEC: begin
                if (dec_class == CL_ALU) rf_we = 1'b1;
            end
            ST_MEM: begin
                mem_bus.mem_req  = 1'b1;
                mem_bus.mem_addr = rf_a;
                if (dec_class == CL_ST) begin
                    mem_bus.mem_we    = 1'b1;
                    mem_bus.mem_wdata = rf_b;
                end
                if (dec_class == CL_LD && mem_bus.mem_ack) begin
                    rf_we   = 1'b1;
                    rf_wsel = RF_WSEL_MEM;
                end
            end
            ST_HALT:  halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_alba_ctrl.sv
// Bench for alba_ctrl: memory/register-file environment, ISA-level reference
// model feeding an expected-event scoreboard, and directed timing scenarios.
module tb_alba_ctrl;

    typedef struct packed {
        logic        is_mem;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  rd;
        logic        sel;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alba_ctrl_if mif();

    logic [3:0]  rf_ra, rf_rb, rf_rd;
    logic [15:0] rf_a, rf_b;
    logic        rf_we, rf_wsel;
    logic [2:0]  alu_op;
    logic [7:0]  alu_imm;
    logic [3:0]  alu_shamt;
    logic        halted;

    alba_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_bus(mif),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd(rf_rd),
        .rf_a(rf_a), .rf_b(rf_b), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .alu_op(alu_op), .alu_imm(alu_imm), .alu_shamt(alu_shamt),
        .halted(halted)
    );

    logic [15:0] mem   [0:65535];
    logic [15:0] mmem  [0:65535];
    logic [15:0] regs  [0:15];
    logic [15:0] mregs [0:15];
    int          wait_left = 0;
    int          wait_seq[$];
    bit          rand_wait = 0;
    ev_t         exp_q[$];
    logic [15:0] last_hs_addr = 16'h0000;
    bit          model_halts;
    int          n_checks = 0;
    int          n_fail = 0;

    assign mif.mem_ack   = mif.mem_req && (wait_left == 0);
    assign mif.mem_rdata = mem[mif.mem_addr];
    assign rf_a = regs[rf_ra];
    assign rf_b = regs[rf_rb];

    // Stand-in for the downstream ALU so register writes carry checkable data.
    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] imm,
                                          input logic [3:0] sh);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {8'h00, imm};
            3'd6:    return a << sh;
            default: return a + {8'h00, imm};
        endcase
    endfunction

    function automatic int next_wait();
        if (wait_seq.size() > 0) return wait_seq.pop_front();
        if (rand_wait) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e = '{is_mem: 1'b1, we: we, addr: a, data: d, rd: 4'h0, sel: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_reg(input logic [3:0] rd, input logic sel, input logic [15:0] d);
        ev_t e;
        e = '{is_mem: 1'b0, we: 1'b0, addr: 16'h0000, data: d, rd: rd, sel: sel};
        exp_q.push_back(e);
    endtask

    // Instruction-level model: executes the program and lists every bus
    // transaction and register write in the order the core must produce them.
    task automatic run_model(input int limit, output bit halts);
        logic [15:0] pc, ir, a, v;
        pc = 16'h0000;
        halts = 0;
        for (int n = 0; n < limit && !halts; n++) begin
            ir = mmem[pc];
            push_mem(1'b0, pc, 16'h0000);
            pc = pc + 16'd1;
            a = mregs[ir[7:4]];
            case (ir[15:12])
                4'h8: begin
                    push_mem(1'b0, a, 16'h0000);
                    v = mmem[a];
                    push_reg(ir[11:8], 1'b1, v);
                    mregs[ir[11:8]] = v;
                end
                4'h9: begin
                    push_mem(1'b1, a, mregs[ir[3:0]]);
                    mmem[a] = mregs[ir[3:0]];
                end
                4'hA: if (mregs[ir[11:8]] == 16'h0000) pc = pc + 16'($signed(ir[7:0]));
                4'hB: pc = a;
                4'hF: halts = 1;
                4'hC, 4'hD, 4'hE: ;
                default: begin
                    v = alu_f(ir[14:12], a, mregs[ir[3:0]], ir[7:0], ir[3:0]);
                    push_reg(ir[11:8], 1'b0, v);
                    mregs[ir[11:8]] = v;
                end
            endcase
        end
    endtask

    // Environment: applies memory writes, register writes and wait states.
    initial begin
        bit hs, hwe, pend, wr;
        logic [15:0] ha, hd, wv;
        logic [3:0] wrd;
        forever begin
            @(negedge clk);
            hs   = !reset && mif.mem_req && mif.mem_ack;
            pend = !reset && mif.mem_req && !mif.mem_ack;
            hwe  = mif.mem_we;
            ha   = mif.mem_addr;
            hd   = mif.mem_wdata;
            wr   = !reset && rf_we;
            wrd  = rf_rd;
            wv   = rf_wsel ? mif.mem_rdata : alu_f(alu_op, rf_a, rf_b, alu_imm, alu_shamt);
            @(posedge clk);
            #1;
            if (reset) continue;
            if (hs) begin
                if (hwe) mem[ha] = hd;
                last_hs_addr = ha;
                wait_left = next_wait();
            end else if (pend && wait_left > 0) begin
                wait_left = wait_left - 1;
            end
            if (wr) regs[wrd] = wv;
        end
    end

    // Monitor: pops expected events as the DUT presents them.
    initial begin
        logic        p_pend, p_we;
        logic [15:0] p_addr, p_wdata, v;
        ev_t e;
        p_pend = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_pend = 0;
                continue;
            end
            if (p_pend && mif.mem_req)
                check("req_stable", {15'h0, mif.mem_we, mif.mem_addr}, {15'h0, p_we, p_addr});
            if (p_pend && mif.mem_req)
                check("req_wdata_stable", {16'h0, mif.mem_wdata}, {16'h0, p_wdata});
            if (mif.mem_req && mif.mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mem_txn", {15'h0, mif.mem_we, mif.mem_addr}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_kind", {31'h0, 1'b1}, {31'h0, e.is_mem});
                    check("mem_txn", {mif.mem_we, mif.mem_addr, mif.mem_wdata[14:0]},
                          {e.we, e.addr, e.data[14:0]});
                end
            end
            if (rf_we) begin
                v = rf_wsel ? mif.mem_rdata : alu_f(alu_op, rf_a, rf_b, alu_imm, alu_shamt);
                if (exp_q.size() == 0) begin
                    check("unexpected_rf_we", {11'h0, rf_wsel, rf_rd, v}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_write", {e.is_mem, 10'h0, rf_wsel, rf_rd, v},
                          {1'b0, 10'h0, e.sel, e.rd, e.data});
                end
            end
            p_pend  = mif.mem_req && !mif.mem_ack;
            p_we    = mif.mem_we;
            p_addr  = mif.mem_addr;
            p_wdata = mif.mem_wdata;
        end
    end

    task automatic init_phase();
        reset = 1'b1;
        exp_q.delete();
        wait_seq.delete();
        rand_wait = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 16'h0000;
            mmem[i] = 16'h0000;
        end
        for (int r = 0; r < 16; r++) begin
            regs[r]  = 16'h0000;
            mregs[r] = 16'h0000;
        end
        @(posedge clk);
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] v);
        mem[a]  = v;
        mmem[a] = v;
    endtask

    task automatic setreg(input int r, input logic [15:0] v);
        regs[r]  = v;
        mregs[r] = v;
    endtask

    task automatic start();
        run_model(300, model_halts);
        wait_left = next_wait();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic finish_phase(input string nm);
        bit done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk);
            #2;
            done = model_halts ? (halted === 1'b1) : (exp_q.size() == 0);
        end
        check({nm, "_complete"}, {31'h0, done}, 32'h1);
        check({nm, "_drained"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_req, second_req, we_cnt, cnt_a, cnt_b;
        logic prev_req;
        logic [15:0] sec_addr, w_addr, w_data;
        logic [2:0] op_s;
        logic [7:0] imm_s;
        logic [3:0] rd_s;

        // Reset values.
        #12;
        check("rst_mem_req", {31'h0, mif.mem_req}, 32'h0);
        check("rst_rf_we", {31'h0, rf_we}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_outputs", {mif.mem_addr, mif.mem_wdata}, 32'h0);
        check("rst_decode", {17'h0, alu_op, alu_imm, rf_rd}, 32'h0);

        // ALU op with zero-wait memory.
        init_phase();
        put(16'h0000, 16'h7305);
        put(16'h0001, 16'hF000);
        setreg(0, 16'h1111); setreg(5, 16'h0202);
        start();
        first_req = 0; second_req = 0; we_cnt = 0; prev_req = 0;
        sec_addr = 16'hDEAD; op_s = 0; imm_s = 0; rd_s = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mif.mem_req && !prev_req) begin
                if (first_req == 0) first_req = i;
                else if (second_req == 0) begin
                    second_req = i;
                    sec_addr = mif.mem_addr;
                end
            end
            if (rf_we) begin
                we_cnt++;
                op_s = alu_op; imm_s = alu_imm; rd_s = rf_rd;
            end
            prev_req = mif.mem_req;
        end
        check("first_req_cycle", first_req, 2);
        check("second_req_cycle", second_req, 5);
        check("pc_after_alu", {16'h0, sec_addr}, 32'h1);
        check("alu_we_pulses", we_cnt, 1);
        check("alu_fields", {17'h0, op_s, imm_s, rd_s}, {17'h0, 3'd7, 8'h05, 4'd3});
        finish_phase("alu");

        // LD with three data wait cycles.
        init_phase();
        put(16'h0000, 16'h8240);
        put(16'h0001, 16'hF000);
        put(16'h0100, 16'h5A3C);
        setreg(4, 16'h0100);
        wait_seq = '{0, 3};
        start();
        cnt_a = 0; cnt_b = 0; we_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mif.mem_req && !mif.mem_we && mif.mem_addr == 16'h0100) cnt_a++;
            if (rf_we) begin
                we_cnt++;
                if (!(mif.mem_ack && rf_wsel)) cnt_b++;
            end
        end
        check("ld_addr_hold_cycles", cnt_a, 4);
        check("ld_we_pulses", we_cnt, 1);
        check("ld_we_only_on_ack", cnt_b, 0);
        finish_phase("ld");
        check("ld_reg_value", {16'h0, regs[2]}, 32'h5A3C);

        // ST: one write, no register write.
        init_phase();
        put(16'h0000, 16'h9012);
        put(16'h0001, 16'hF000);
        setreg(1, 16'h0020); setreg(2, 16'hBEEF);
        start();
        cnt_a = 0; we_cnt = 0; w_addr = 0; w_data = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
                cnt_a++;
                w_addr = mif.mem_addr; w_data = mif.mem_wdata;
            end
            if (rf_we) we_cnt++;
        end
        check("st_writes", cnt_a, 1);
        check("st_write_bus", {w_addr, w_data}, {16'h0020, 16'hBEEF});
        check("st_no_rf_we", we_cnt, 0);
        finish_phase("st");
        check("st_mem_value", {16'h0, mem[16'h0020]}, 32'hBEEF);

        // BZ at pc 0x0010, imm -2: taken and not taken.
        for (int t = 0; t < 2; t++) begin
            init_phase();
            put(16'h0000, 16'hB050);
            put(16'h0010, 16'hA1FE);
            put(16'h000F, 16'hF000);
            put(16'h0011, 16'hF000);
            setreg(5, 16'h0010);
            setreg(1, (t == 0) ? 16'h0000 : 16'h0001);
            rand_wait = (t == 1);
            start();
            finish_phase("bz");
            check("bz_target", {16'h0, last_hs_addr}, (t == 0) ? 32'h000F : 32'h0011);
        end

        // PC wrap from 0xFFFF to a HALT at 0 (written by a preceding ST).
        init_phase();
        put(16'h0000, 16'h9012);
        put(16'h0001, 16'hB050);
        put(16'hFFFF, 16'hC000);
        setreg(1, 16'h0000); setreg(2, 16'hF000); setreg(5, 16'hFFFF);
        start();
        finish_phase("wrap");
        check("wrap_halt_addr", {16'h0, last_hs_addr}, 32'h0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.mem_req) cnt_a++;
            if (!halted) cnt_b++;
        end
        check("halt_no_req", cnt_a, 0);
        check("halt_held", cnt_b, 0);

        // Reset during an unacknowledged fetch.
        init_phase();
        put(16'h0000, 16'h7305);
        put(16'h0001, 16'hF000);
        wait_seq = '{8};
        start();
        repeat (3) @(negedge clk);
        check("midrst_req_before", {31'h0, mif.mem_req}, 32'h1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_req_drops", {30'h0, mif.mem_req, rf_we}, 32'h0);
        wait_left = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        first_req = 0;
        sec_addr = 16'hDEAD;
        for (int i = 1; i <= 4 && first_req == 0; i++) begin
            @(negedge clk);
            if (mif.mem_req) begin
                first_req = i;
                sec_addr = mif.mem_addr;
            end
        end
        check("midrst_refetch_cycle", first_req, 2);
        check("midrst_refetch_addr", {16'h0, sec_addr}, 32'h0);
        finish_phase("midrst");

        // Randomized programs with random wait states.
        for (int p = 0; p < 6; p++) begin
            init_phase();
            rand_wait = 1;
            for (int r = 0; r < 16; r++) setreg(r, 16'($urandom));
            for (int r = 0; r < 16; r++)
                if (regs[r] >= 16'h0040) put(regs[r], 16'($urandom));
            for (int a = 0; a < 32; a++) begin
                logic [15:0] ins;
                case ($urandom_range(0, 9))
                    4: ins = {4'h8, 4'($urandom), 4'($urandom), 4'h0};
                    5: ins = {4'h9, 4'h0, 4'($urandom), 4'($urandom)};
                    6: ins = {4'hA, 4'($urandom), 8'($urandom_range(1, 3))};
                    7: ins = {4'($urandom_range(12, 14)), 12'($urandom)};
                    default: ins = {1'b0, 3'($urandom), 12'($urandom)};
                endcase
                put(16'(a), ins);
            end
            for (int a = 32; a < 36; a++) put(16'(a), 16'hF000);
            start();
            finish_phase("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alba_ctrl.md
# alba_ctrl

Multicycle fetch/decode/execute sequencer for albaCore, directly upstream of the ALU. It fetches 16-bit instructions from a single-port memory over a req/ack handshake and holds the instruction register and PC. It decodes each instruction into ALU controls (`op`, `imm`, `shamt`), register-file addresses and write enables. It also sequences loads, stores, branches and halt.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_req`  out  1  memory request; held until acknowledged.
- `mem_we`  out  1  1 = store, 0 = read.
- `mem_addr`  out  16  PC during fetch; `rf_a` during LD/ST.
- `mem_wdata`  out  16  equals `rf_b` during ST, 0 otherwise.
- `mem_rdata`  in  16  read data, valid in the ack cycle.
- `mem_ack`  in  1  completes the transaction in the cycle where `mem_req && mem_ack`.
- `rf_ra`, `rf_rb`, `rf_rd`  out  4 each  register-file read A, read B and write addresses.
- `rf_a`, `rf_b`  in  16 each  register-file read data for `rf_ra` and `rf_rb`.
- `rf_we`  out  1  register write strobe, single-cycle pulse.
- `rf_wsel`  out  1  write source: 0 = ALU `f`, 1 = `mem_rdata`.
- `alu_op`  out  3  ALU opcode.
- `alu_imm`  out  8  equals `ir[7:0]`.
- `alu_shamt`  out  4  equals `ir[3:0]`.
- `halted`  out  1  high in HALT.

## Operation
Instruction format:
- `ir[15:12]` = opcode; `ir[11:8]` = rd; `ir[7:4]` = ra; `ir[3:0]` = rb or shamt; `ir[7:0]` = imm.

Opcodes:
- 0–7: ALU ops, passed straight through as `alu_op = ir[14:12]`. The ALU result is written to rd.
- 8 LD: `rd ← mem[reg[ra]]`.
- 9 ST: `mem[reg[ra]] ← reg[rb]`.
- A BZ: if `reg[rd] == 0`, then `pc ← pc + sext(imm)`. Here `pc` is already incremented; `rf_ra` is driven with `ir[11:8]` for this test.
- B JMP: `pc ← reg[ra]`.
- F HALT.
- C, D, E: NOP (no writes, no memory access).

State machine:
- BOOT: reset state; all outputs 0; next state FETCH.
- FETCH: `mem_req = 1`, `mem_we = 0`, `mem_addr = pc`. On ack: `ir ← mem_rdata`, `pc ← pc + 1` (wraps 16'hFFFF → 16'h0000); next state DECODE.
- DECODE: one cycle; register addresses from the new `ir` settle; next state EXEC.
- EXEC, by opcode:
  - ALU op: `rf_we = 1`, `rf_wsel = 0`, next FETCH.
  - LD/ST: next MEM.
  - BZ/JMP: update `pc`, next FETCH.
  - NOP: next FETCH.
  - HALT: next HALT.
- MEM: `mem_req = 1`, `mem_addr = rf_a`, `mem_we = (op == ST)`. On ack: for LD, `rf_we = 1` and `rf_wsel = 1` in that same cycle. Next FETCH.
- HALT: `halted = 1`; no requests; only reset exits.

Rules:
- `rf_ra`/`rf_rb`/`rf_rd`, `alu_op`, `alu_imm` and `alu_shamt` decode combinationally from `ir` in every state.
- `rf_we` is asserted only in EXEC or on the LD ack cycle.
- `mem_ack` is ignored while `mem_req = 0`.
- Branch arithmetic is modulo 2^16.

## Timing
- Reset values: state BOOT, `pc = RESET_PC`, `ir = 0`. All outputs 0, except the decode outputs, which reflect `ir = 0`.
- First `mem_req` is asserted in the second cycle after reset deasserts.
- A zero-wait memory acks in the same cycle `req` rises. Per instruction:
  - ALU/BZ/JMP/NOP: 3 cycles.
  - LD/ST: 4 cycles.
  - Each memory wait cycle adds 1.
- Request stability: `mem_addr`, `mem_we` and `mem_wdata` stay constant while `mem_req` is high and unacked.
- Reset mid-operation: the asynchronous reset drops `mem_req` and `rf_we` immediately. An in-flight transaction is abandoned with no state update.
- JMP to the current PC is legal (self-loop).

## Structure
- Shared package `alba_pkg` holds:
  - opcode constants (`OP_LD = 4'h8`, `OP_ST`, `OP_BZ`, `OP_JMP`, `OP_HALT = 4'hF`);
  - state encodings (BOOT, FETCH, DECODE, EXEC, MEM, HALT);
  - `RF_WSEL_ALU` / `RF_WSEL_MEM`.
- One sub-module is natural: `alba_decode`, combinational, mapping `ir` to field and class signals. The FSM, PC and IR stay in `alba_ctrl`.

## Test plan
- Reset release with zero-wait memory and mem[0] = 16'h7305 (op 7, rd 3) → `mem_req` is first asserted 2 cycles after release. EXEC shows `alu_op = 7`, `alu_imm = 8'h05`, `rf_rd = 3`, `rf_we` pulses once, and `pc` = 1.
- LD with 3 wait cycles, mem[0] = 16'h8240 and `rf_a = 16'h0100` → MEM holds `mem_addr = 16'h0100` stable for 4 cycles. `rf_we = 1` and `rf_wsel = 1` occur only in the ack cycle.
- ST 16'h9012 with `rf_a = 16'h0020`, `rf_b = 16'hBEEF` → a single write with `mem_we = 1`, `mem_addr = 16'h0020`, `mem_wdata = 16'hBEEF`, and no `rf_we`.
- BZ at pc 16'h0010 with imm 8'hFE → when `rf_a = 0`, the next fetch address is 16'h000F. When `rf_a = 1`, the next fetch address is 16'h0011.
- Fetch at 16'hFFFF (NOP, opcode C) → `pc` wraps to 16'h0000. Then HALT at 0 → `halted = 1` with no further `mem_req` for 20 cycles.
- Assert `reset` during an unacked FETCH → `mem_req` falls immediately. After release, the core refetches from `RESET_PC`.
